// File: rtl/pim_cfu_sequencer.sv
// CFU-side controller for the bit-serial PIM macro: decodes CFU commands and sequences
// macro write, read and MAC phases, holding the row-wordline mask and returning results.
module pim_cfu_sequencer #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned PWIDTH   = 32,
    parameter int unsigned PDEPTH   = 256,
    parameter int unsigned MAX_BITS = 32,
    parameter int unsigned DRAIN    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_payload_function_id,
    input  logic [DWIDTH-1:0] cmd_payload_inputs_0,
    input  logic [DWIDTH-1:0] cmd_payload_inputs_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_payload_outputs_0,
    output logic              rsp_payload_response_ok,
    output logic [AWIDTH-1:0] pim_addr,
    output logic [PWIDTH-1:0] pim_wdata,
    output logic              pim_w_en,
    output logic              pim_p_en,
    output logic [PDEPTH-1:0] pim_rwl,
    input  logic [PWIDTH-1:0] pim_q,
    input  logic [DWIDTH-1:0] pim_mac_out,
    output logic              busy
);

    localparam int unsigned KW = (PDEPTH > 32) ? $clog2(PDEPTH / 32) : 1;
    localparam int unsigned CW = $clog2(MAX_BITS + DRAIN + 1);

    localparam logic [2:0] OP_WRITE  = 3'd0;
    localparam logic [2:0] OP_READ   = 3'd1;
    localparam logic [2:0] OP_SETRWL = 3'd2;
    localparam logic [2:0] OP_MAC    = 3'd3;
    localparam logic [2:0] OP_GETRWL = 3'd4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_RDWAIT = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_CAPT   = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    logic [2:0]        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [PDEPTH-1:0] rwl_n;
    logic [AWIDTH-1:0] addr_n;
    logic [PWIDTH-1:0] wdata_n;
    logic [DWIDTH-1:0] data_n;
    logic              ok_n;

    logic              accept;
    logic [2:0]        op;
    logic [5:0]        nbits;
    logic [KW-1:0]     chunk;
    logic              unused_bits;

    assign accept      = cmd_valid & cmd_ready;
    assign op          = cmd_payload_function_id[2:0];
    assign nbits       = cmd_payload_inputs_0[5:0];
    assign chunk       = cmd_payload_inputs_1[KW-1:0];
    assign unused_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[DWIDTH-1:AWIDTH]};

    // Next-state and next-register values; response data/ok only change on entry paths to RESP.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rwl_n   = pim_rwl;
        addr_n  = pim_addr;
        wdata_n = pim_wdata;
        data_n  = rsp_payload_outputs_0;
        ok_n    = rsp_payload_response_ok;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    data_n  = '0;
                    ok_n    = 1'b1;
                    state_n = S_RESP;
                    case (op)
                        OP_WRITE: begin
                            addr_n  = cmd_payload_inputs_1[AWIDTH-1:0];
                            wdata_n = PWIDTH'(cmd_payload_inputs_0);
                            state_n = S_WRITE;
                        end
                        OP_READ: begin
                            addr_n  = cmd_payload_inputs_1[AWIDTH-1:0];
                            state_n = S_READ;
                        end
                        OP_SETRWL: begin
                            data_n = DWIDTH'(pim_rwl[{chunk, 5'd0} +: 32]);
                            rwl_n[{chunk, 5'd0} +: 32] = 32'(cmd_payload_inputs_0);
                        end
                        OP_MAC: begin
                            if (32'(nbits) > MAX_BITS) begin
                                ok_n = 1'b0;
                            end else if (nbits != 6'd0) begin
                                cnt_n   = CW'(32'(nbits) + DRAIN);
                                state_n = S_RUN;
                            end
                        end
                        OP_GETRWL: begin
                            data_n = DWIDTH'(pim_rwl[{chunk, 5'd0} +: 32]);
                        end
                        default: begin
                            ok_n = 1'b0;
                        end
                    endcase
                end
            end
            S_WRITE:  state_n = S_RESP;
            S_READ:   state_n = S_RDWAIT;
            S_RDWAIT: begin
                data_n  = DWIDTH'(pim_q);
                state_n = S_RESP;
            end
            // p_en stays high for exactly n+DRAIN cycles, then one idle CAPT cycle
            S_RUN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = S_CAPT;
                end
            end
            S_CAPT: begin
                data_n  = pim_mac_out;
                state_n = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= S_IDLE;
            cnt                     <= '0;
            pim_rwl                 <= '0;
            pim_addr                <= '0;
            pim_wdata               <= '0;
            rsp_payload_outputs_0   <= '0;
            rsp_payload_response_ok <= 1'b0;
            cmd_ready               <= 1'b0;
            rsp_valid               <= 1'b0;
            pim_w_en                <= 1'b0;
            pim_p_en                <= 1'b0;
            busy                    <= 1'b0;
        end else begin
            state                   <= state_n;
            cnt                     <= cnt_n;
            pim_rwl                 <= rwl_n;
            pim_addr                <= addr_n;
            pim_wdata               <= wdata_n;
            rsp_payload_outputs_0   <= data_n;
            rsp_payload_response_ok <= ok_n;
            cmd_ready               <= (state_n == S_IDLE);
            rsp_valid               <= (state_n == S_RESP);
            pim_w_en                <= (state_n == S_WRITE);
            pim_p_en                <= (state_n == S_RUN);
            busy                    <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_pim_cfu_sequencer.sv
// Bench for pim_cfu_sequencer: directed vector table, hand-built corner sequences and
// randomized commands scored against a command-level model, with a behavioural macro attached.
module tb_pim_cfu_sequencer;

    localparam int unsigned DRAIN    = 2;
    localparam int unsigned MAX_BITS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        rsp_payload_response_ok;
    logic [7:0]  pim_addr;
    logic [31:0] pim_wdata;
    logic        pim_w_en, pim_p_en;
    logic [255:0] pim_rwl;
    logic [31:0] pim_q, pim_mac_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pim_cfu_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .rsp_payload_response_ok (rsp_payload_response_ok),
        .pim_addr                (pim_addr),
        .pim_wdata               (pim_wdata),
        .pim_w_en                (pim_w_en),
        .pim_p_en                (pim_p_en),
        .pim_rwl                 (pim_rwl),
        .pim_q                   (pim_q),
        .pim_mac_out             (pim_mac_out),
        .busy                    (busy)
    );

    // Behavioural macro: memory, registered read, and a MAC equal to popcount of the
    // selected rows times the number of non-drain p_en cycles in the last burst.
    logic [31:0] mac_mem [256];
    logic        mem_init = 1'b0;
    logic        pen_d = 1'b0;
    int          burst = 0;
    int          popsel;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int r = 0; r < 256; r++) mac_mem[r] <= 32'h0;
            mem_init <= 1'b1;
        end else if (pim_w_en) begin
            mac_mem[pim_addr] <= pim_wdata;
        end
        pim_q <= mac_mem[pim_addr];
        pen_d <= pim_p_en;
        if (pim_p_en) burst <= pen_d ? burst + 1 : 1;
    end

    always_comb begin
        popsel = 0;
        for (int r = 0; r < 256; r++) begin
            if (pim_rwl[r[7:0]]) popsel = popsel + $countones(mac_mem[r[7:0]]);
        end
        pim_mac_out = (burst >= int'(DRAIN)) ? 32'(popsel * (burst - int'(DRAIN))) : 32'h0;
    end

    // Free-running activity monitor; tests take differences of these totals.
    int           pen_total = 0;
    int           wen_total = 0;
    int           rwl_chg = 0;
    logic [255:0] rwl_prev = '0;
    always @(negedge clk) begin
        if (pim_p_en) pen_total = pen_total + 1;
        if (pim_w_en) wen_total = wen_total + 1;
        if (pim_p_en && pim_rwl != rwl_prev) rwl_chg = rwl_chg + 1;
        rwl_prev = pim_rwl;
    end

    // Command-level reference model
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rwl [8];

    task automatic ref_cmd(input logic [2:0] op, input logic [31:0] in0, input logic [31:0] in1,
                           output logic [31:0] d, output logic ok, output int pen, output int wen);
        int n;
        int pop;
        d = 32'h0; ok = 1'b1; pen = 0; wen = 0;
        n = int'(in0[5:0]);
        case (op)
            3'd0: begin ref_mem[in1[7:0]] = in0; wen = 1; end
            3'd1: d = ref_mem[in1[7:0]];
            3'd2: begin d = ref_rwl[in1[2:0]]; ref_rwl[in1[2:0]] = in0; end
            3'd3: begin
                if (n > int'(MAX_BITS)) ok = 1'b0;
                else if (n > 0) begin
                    pop = 0;
                    for (int r = 0; r < 256; r++)
                        if (ref_rwl[r[7:5]][r[4:0]]) pop = pop + $countones(ref_mem[r[7:0]]);
                    d = 32'(pop * n);
                    pen = n + int'(DRAIN);
                end
            end
            3'd4: d = ref_rwl[in1[2:0]];
            default: ok = 1'b0;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s timeout actual=no-handshake required=handshake", name);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [2:0] op, input logic [31:0] in0, input logic [31:0] in1,
                        output bit tmo);
        bit done;
        logic [31:0] rnd;
        tmo = 1'b1;
        rnd = $urandom();
        cmd_payload_function_id = {rnd[6:0], op};
        cmd_payload_inputs_0 = in0;
        cmd_payload_inputs_1 = in1;
        cmd_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            done = cmd_ready;
            @(posedge clk); #1;
            if (done) begin tmo = 1'b0; break; end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input bit rand_ready, output logic [31:0] d, output logic ok,
                           output bit tmo);
        bit done;
        logic [31:0] rnd;
        tmo = 1'b1; d = 32'h0; ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            rnd = $urandom();
            rsp_ready = rand_ready ? rnd[0] : 1'b1;
            d = rsp_payload_outputs_0;
            ok = rsp_payload_response_ok;
            done = rsp_valid && rsp_ready;
            @(posedge clk); #1;
            if (done) begin tmo = 1'b0; break; end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [2:0] op, input logic [31:0] in0,
                           input logic [31:0] in1, input logic [31:0] exp_d, input logic exp_ok,
                           input int exp_pen, input int exp_wen, input bit rand_ready);
        int p0, w0;
        bit tmo;
        logic [31:0] d;
        logic ok;
        p0 = pen_total; w0 = wen_total;
        send(op, in0, in1, tmo);
        if (tmo) begin timeout_fail({name, "_cmd"}); return; end
        get_rsp(rand_ready, d, ok, tmo);
        if (tmo) begin timeout_fail({name, "_rsp"}); return; end
        chk({name, "_data"}, d, exp_d);
        chk({name, "_ok"}, 32'(ok), 32'(exp_ok));
        chk({name, "_pen_cycles"}, 32'(pen_total - p0), 32'(exp_pen));
        chk({name, "_wen_cycles"}, 32'(wen_total - w0), 32'(exp_wen));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] data;
        logic        ok;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        logic [31:0] ed, d0, rnd0, rnd1;
        logic        eok;
        int          epen, ewen, acc, w0, row, n;
        bit          tmo, seen;
        int          opsel [10] = '{0, 0, 1, 1, 2, 3, 3, 4, 5, 7};
        logic [2:0]  op;
        logic [31:0] in0, in1;

        vecs[0]  = '{3'd0, 32'hDEADBEEF, 32'h0000_0005, 32'h0,        1'b1};
        vecs[1]  = '{3'd1, 32'h0,        32'h0000_0005, 32'hDEADBEEF, 1'b1};
        vecs[2]  = '{3'd1, 32'h0,        32'hFFFF_FF05, 32'hDEADBEEF, 1'b1};
        vecs[3]  = '{3'd2, 32'h0000_0001, 32'h0,        32'h0,        1'b1};
        vecs[4]  = '{3'd0, 32'hFFFFFFFF, 32'h0,         32'h0,        1'b1};
        vecs[5]  = '{3'd3, 32'd1,        32'h0,         32'd32,       1'b1};
        vecs[6]  = '{3'd3, 32'd0,        32'h0,         32'h0,        1'b1};
        vecs[7]  = '{3'd3, 32'd33,       32'h0,         32'h0,        1'b0};
        vecs[8]  = '{3'd6, 32'h1234_5678, 32'h9,        32'h0,        1'b0};
        vecs[9]  = '{3'd2, 32'hA5A5A5A5, 32'h7,         32'h0,        1'b1};
        vecs[10] = '{3'd4, 32'h0,        32'h7,         32'hA5A5A5A5, 1'b1};
        vecs[11] = '{3'd2, 32'h0000_0003, 32'h8,        32'h0000_0001, 1'b1};
        vecs[12] = '{3'd3, 32'hFFFF_FFE0, 32'h0,        32'd1024,     1'b1};
        vecs[13] = '{3'd3, 32'd63,       32'h0,         32'h0,        1'b0};

        for (int r = 0; r < 256; r++) ref_mem[r] = 32'h0;
        for (int k = 0; k < 8; k++) ref_rwl[k] = 32'h0;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_payload_function_id = '0; cmd_payload_inputs_0 = '0; cmd_payload_inputs_1 = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_p_en", 32'(pim_p_en), 32'h0);
        chk("rst_w_en", 32'(pim_w_en), 32'h0);
        chk("rst_rwl_zero", 32'(pim_rwl != '0), 32'h0);
        chk("rst_rsp_data", rsp_payload_outputs_0, 32'h0);
        chk("rst_addr", 32'(pim_addr), 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            ref_cmd(vecs[i].op, vecs[i].in0, vecs[i].in1, ed, eok, epen, ewen);
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].in0, vecs[i].in1,
                    vecs[i].data, vecs[i].ok, epen, ewen, 1'b0);
        end
        chk("rwl_chunk7", pim_rwl[255:224], 32'hA5A5A5A5);
        chk("rwl_chunk0", pim_rwl[31:0], 32'h0000_0003);

        // Backpressure: response held, new command ignored
        ref_cmd(3'd0, 32'h13579BDF, 32'd9, ed, eok, epen, ewen);
        send(3'd0, 32'h13579BDF, 32'd9, tmo);
        if (tmo) timeout_fail("bp_cmd");
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (rsp_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!seen) timeout_fail("bp_rsp");
        w0 = wen_total;
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0 = 32'hBAD0BAD0;
        cmd_payload_inputs_1 = 32'd10;
        cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp_rsp_data_c%0d", c), rsp_payload_outputs_0, 32'h0);
            chk($sformatf("bp_cmd_ready_c%0d", c), 32'(cmd_ready), 32'h0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_no_write", 32'(wen_total - w0), 32'h0);
        ref_cmd(3'd1, 32'h0, 32'd10, ed, eok, epen, ewen);
        run_one("bp_read10", 3'd1, 32'h0, 32'd10, ed, eok, epen, ewen, 1'b0);
        ref_cmd(3'd1, 32'h0, 32'd9, ed, eok, epen, ewen);
        run_one("bp_read9", 3'd1, 32'h0, 32'd9, ed, eok, epen, ewen, 1'b0);

        // Back-to-back WRITE throughput: one accept every 3 cycles
        ref_cmd(3'd0, 32'h0F0F0F0F, 32'd12, ed, eok, epen, ewen);
        w0 = wen_total;
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0 = 32'h0F0F0F0F;
        cmd_payload_inputs_1 = 32'd12;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            if (cmd_ready) acc = acc + 1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd4);
        chk("b2b_wen_pulses", 32'(wen_total - w0), 32'd4);

        // Reset in the third p_en cycle of a 10-bit MAC
        send(3'd3, 32'd10, 32'h0, tmo);
        if (tmo) timeout_fail("rstmac_cmd");
        repeat (2) @(posedge clk);
        #1;
        chk("rstmac_p_en_before", 32'(pim_p_en), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rstmac_p_en", 32'(pim_p_en), 32'h0);
        chk("rstmac_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstmac_busy", 32'(busy), 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmac_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rstmac_rsp_valid2", 32'(rsp_valid), 32'h0);
        chk("rstmac_rwl_zero", 32'(pim_rwl != '0), 32'h0);
        for (int k = 0; k < 8; k++) ref_rwl[k] = 32'h0;

        // Randomized commands against the reference model
        for (int i = 0; i < 80; i++) begin
            rnd0 = $urandom();
            rnd1 = $urandom();
            op = 3'(opsel[$urandom_range(0, 9)]);
            row = $urandom_range(0, 15);
            row = (row < 8) ? row : 216 + row;
            in1 = {rnd1[31:8], 8'(row)};
            in0 = rnd0;
            if (op == 3'd3) begin
                n = $urandom_range(0, 36);
                in0 = {rnd0[31:6], 6'(n)};
            end
            ref_cmd(op, in0, in1, ed, eok, epen, ewen);
            run_one($sformatf("rnd%0d_op%0d", i, op), op, in0, in1, ed, eok, epen, ewen, 1'b1);
        end

        chk("rwl_stable_during_p_en", 32'(rwl_chg), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
